// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite compositor: colour key, animation state encoding, word typedefs.
package sprite_pkg;

   localparam logic [7:0] TRANSPARENT_COLOR = 8'hE3;
   localparam int         STATE_COUNT       = 11;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      WALK      = 4'd1,
      WALKBACK  = 4'd2,
      ATK_START = 4'd3,
      ATK_END   = 4'd4,
      ATK_PULL  = 4'd5,
      DIR_START = 4'd6,
      DIR_END   = 4'd7,
      DIR_PULL  = 4'd8,
      GOTHIT    = 4'd9,
      BLOCK     = 4'd10
   } sprite_state_e;

   typedef logic [9:0] coord_t;
   typedef logic [7:0] color_t;

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel, position, ROM and composited-output bundle of the sprite compositor.
interface sprite_compositor_if #(
   parameter int NUM_CH  = 2,
   parameter int COORD_W = 10,
   parameter int ADDR_W  = 15,
   parameter int PIX_W   = 8
);
   // pix_valid/out_valid are valid-only strobes with no ready: the pipeline never
   // stalls, and every pixel presented with pix_valid=1 reappears exactly three
   // cycles later with out_valid=1; rom_data must answer rom_addr one cycle later.
   logic                        frame_start;
   logic                        pix_valid;
   logic [COORD_W-1:0]          pix_x;
   logic [COORD_W-1:0]          pix_y;
   logic [NUM_CH*COORD_W-1:0]   pos_x;
   logic [NUM_CH*COORD_W-1:0]   pos_y;
   logic [NUM_CH*4-1:0]         state;
   logic [NUM_CH-1:0]           facing;
   logic [NUM_CH*ADDR_W-1:0]    rom_addr;
   logic [NUM_CH*4-1:0]         rom_sel;
   logic [NUM_CH*PIX_W-1:0]     rom_data;
   logic                        out_valid;
   logic                        visible;
   logic [PIX_W-1:0]            data;
   logic [2:0]                  owner;
   logic                        collision;

   modport master (
      output frame_start, pix_valid, pix_x, pix_y, pos_x, pos_y, state, facing, rom_data,
      input  rom_addr, rom_sel, out_valid, visible, data, owner, collision
   );

   modport slave (
      input  frame_start, pix_valid, pix_x, pix_y, pos_x, pos_y, state, facing, rom_data,
      output rom_addr, rom_sel, out_valid, visible, data, owner, collision
   );

endinterface

// File: rtl/sprite_channel.sv
// One sprite channel: per-frame shadow registers, bounds check and registered ROM address (stage A).
// Horizontal mirroring is compiled in only when SPRITE_MIRROR_EN is defined.
module sprite_channel
   import sprite_pkg::*;
#(
   parameter int SPR_W   = 113,
   parameter int SPR_H   = 200,
   parameter int COORD_W = 10,
   parameter int ADDR_W  = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start_i,
   input  logic               pix_valid_i,
   input  logic [COORD_W-1:0] pix_x_i,
   input  logic [COORD_W-1:0] pix_y_i,
   input  logic [COORD_W-1:0] pos_x_i,
   input  logic [COORD_W-1:0] pos_y_i,
   input  logic [3:0]         state_i,
   input  logic               facing_i,
   output logic [ADDR_W-1:0]  rom_addr_o,
   output logic [3:0]         rom_sel_o,
   output logic               inside_o
);

   localparam logic [COORD_W:0]  SPR_W_C  = (COORD_W+1)'(SPR_W);
   localparam logic [COORD_W:0]  SPR_H_C  = (COORD_W+1)'(SPR_H);
   localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(SPR_W);
   localparam logic [ADDR_W-1:0] MIR_BASE = ADDR_W'(SPR_W - 1);

   logic [COORD_W-1:0] pos_x_q, pos_x_d;
   logic [COORD_W-1:0] pos_y_q, pos_y_d;
   logic [3:0]         state_q, state_d;
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic [3:0]         rom_sel_q;
   logic               inside_q, inside_d;
   logic [COORD_W:0]   x_ext, y_ext, px_ext, py_ext;
   logic [COORD_W-1:0] rel_x, rel_y;
   logic [ADDR_W-1:0]  rx;

   // The _d values double as the effective shadows: a pixel on the frame_start cycle sees the new frame.
   assign pos_x_d = frame_start_i ? pos_x_i : pos_x_q;
   assign pos_y_d = frame_start_i ? pos_y_i : pos_y_q;
   assign state_d = frame_start_i ? state_i : state_q;

   // One extra bit keeps pos+SPR_W from wrapping near the top of the coordinate range.
   assign x_ext  = {1'b0, pix_x_i};
   assign y_ext  = {1'b0, pix_y_i};
   assign px_ext = {1'b0, pos_x_d};
   assign py_ext = {1'b0, pos_y_d};

   assign inside_d = pix_valid_i
                     && (x_ext >= px_ext) && (x_ext < px_ext + SPR_W_C)
                     && (y_ext >= py_ext) && (y_ext < py_ext + SPR_H_C);

   assign rel_x = pix_x_i - pos_x_d;
   assign rel_y = pix_y_i - pos_y_d;

`ifdef SPRITE_MIRROR_EN
   logic facing_q, facing_d;
   assign facing_d = frame_start_i ? facing_i : facing_q;
   assign rx       = facing_d ? (MIR_BASE - ADDR_W'(rel_x)) : ADDR_W'(rel_x);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) facing_q <= 1'b0;
      else        facing_q <= facing_d;
   end
`else
   logic unused_facing;
   assign unused_facing = facing_i;
   assign rx            = ADDR_W'(rel_x);
`endif

   assign rom_addr_d = inside_d ? (ADDR_W'(rel_y) * STRIDE + rx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_x_q    <= '0;
         pos_y_q    <= '0;
         state_q    <= '0;
         rom_addr_q <= '0;
         rom_sel_q  <= '0;
         inside_q   <= 1'b0;
      end else begin
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         state_q    <= state_d;
         rom_addr_q <= rom_addr_d;
         rom_sel_q  <= state_d;
         inside_q   <= inside_d;
      end
   end

   assign rom_addr_o = rom_addr_q;
   assign rom_sel_o  = rom_sel_q;
   assign inside_o   = inside_q;

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite compositor: per-channel address generation, fixed-priority colour-key compositing
// and per-frame collision flag. Optional mirroring via SPRITE_MIRROR_EN (see sprite_channel).
module sprite_compositor
   import sprite_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int SPR_W      = 113,
   parameter int SPR_H      = 200,
   parameter int COORD_W    = 10,
   parameter int ADDR_W     = 15,
   parameter int PIX_W      = 8,
   parameter int NUM_STATES = STATE_COUNT
) (
   input logic              clk,
   input logic              rst_n,
   sprite_compositor_if.slave bus
);

   localparam logic [PIX_W-1:0] TRANSP  = PIX_W'(TRANSPARENT_COLOR);
   localparam logic [3:0]       ST_LIM  = 4'(NUM_STATES);

   logic [NUM_CH*ADDR_W-1:0] rom_addr_flat;
   logic [NUM_CH*4-1:0]      rom_sel_flat;
   logic [NUM_CH-1:0]        inside_d1;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sprite_channel #(
         .SPR_W   (SPR_W),
         .SPR_H   (SPR_H),
         .COORD_W (COORD_W),
         .ADDR_W  (ADDR_W)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .frame_start_i (bus.frame_start),
         .pix_valid_i   (bus.pix_valid),
         .pix_x_i       (bus.pix_x),
         .pix_y_i       (bus.pix_y),
         .pos_x_i       (bus.pos_x[i*COORD_W +: COORD_W]),
         .pos_y_i       (bus.pos_y[i*COORD_W +: COORD_W]),
         .state_i       (bus.state[i*4 +: 4]),
         .facing_i      (bus.facing[i]),
         .rom_addr_o    (rom_addr_flat[i*ADDR_W +: ADDR_W]),
         .rom_sel_o     (rom_sel_flat[i*4 +: 4]),
         .inside_o      (inside_d1[i])
      );
   end

   assign bus.rom_addr = rom_addr_flat;
   assign bus.rom_sel  = rom_sel_flat;

   logic                 valid_d1_q, valid_d2_q;
   logic [NUM_CH-1:0]    inside_d2_q;
   logic [NUM_CH*4-1:0]  state_d2_q;
   logic [NUM_CH-1:0]    opaque;
   logic [3:0]           n_opaque;
   logic [PIX_W-1:0]     win_data;
   logic [2:0]           win_owner;
   logic                 hit;

   logic                 out_valid_q, visible_q, collision_q, collide_acc_q;
   logic [PIX_W-1:0]     data_q;
   logic [2:0]           owner_q;

   // Bounds and state travel one stage behind the address so they line up with the ROM word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_d1_q  <= 1'b0;
         valid_d2_q  <= 1'b0;
         inside_d2_q <= '0;
         state_d2_q  <= '0;
      end else begin
         valid_d1_q  <= bus.pix_valid;
         valid_d2_q  <= valid_d1_q;
         inside_d2_q <= inside_d1;
         state_d2_q  <= rom_sel_flat;
      end
   end

   // Ascending scan: a later opaque channel overrides, so the highest index wins.
   always_comb begin
      opaque    = '0;
      n_opaque  = '0;
      win_data  = TRANSP;
      win_owner = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         opaque[i] = inside_d2_q[i]
                     && (state_d2_q[i*4 +: 4] < ST_LIM)
                     && (bus.rom_data[i*PIX_W +: PIX_W] != TRANSP);
         if (opaque[i]) begin
            win_data  = bus.rom_data[i*PIX_W +: PIX_W];
            win_owner = 3'(i);
            n_opaque  = n_opaque + 4'd1;
         end
      end
      hit = valid_d2_q && (n_opaque >= 4'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         visible_q     <= 1'b0;
         data_q        <= TRANSP;
         owner_q       <= '0;
         collision_q   <= 1'b0;
         collide_acc_q <= 1'b0;
      end else begin
         out_valid_q <= valid_d2_q;
         visible_q   <= |opaque;
         data_q      <= win_data;
         owner_q     <= win_owner;
         if (bus.frame_start) begin
            collision_q   <= collide_acc_q;
            collide_acc_q <= hit;
         end else if (hit) begin
            collide_acc_q <= 1'b1;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.visible   = visible_q;
   assign bus.data      = data_q;
   assign bus.owner     = owner_q;
   assign bus.collision = collision_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed testbench for sprite_compositor: addressing, priority, collision, shadows, mirror, reset.
module tb_sprite_compositor;
   import sprite_pkg::*;

   localparam int NUM_CH  = 2;
   localparam int COORD_W = 10;
   localparam int ADDR_W  = 15;
   localparam int PIX_W   = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sprite_compositor_if #(
      .NUM_CH(NUM_CH), .COORD_W(COORD_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)
   ) bus ();

   sprite_compositor #(
      .NUM_CH(NUM_CH), .SPR_W(113), .SPR_H(200), .COORD_W(COORD_W),
      .ADDR_W(ADDR_W), .PIX_W(PIX_W), .NUM_STATES(11)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ROM model: one-cycle read latency, one configurable word per channel.
   logic [7:0] word0 = 8'hE3;
   logic [7:0] word1 = 8'hE3;
   always @(posedge clk) bus.rom_data <= {word1, word0};

   int total = 0;
   int bad   = 0;

   // ---------------- driver tasks ----------------
   task automatic set_ch(input int ch, input int x, input int y, input int st, input logic face);
      bus.pos_x[ch*COORD_W +: COORD_W] = COORD_W'(x);
      bus.pos_y[ch*COORD_W +: COORD_W] = COORD_W'(y);
      bus.state[ch*4 +: 4]             = 4'(st);
      bus.facing[ch]                   = face;
   endtask

   task automatic frame_pulse();
      @(negedge clk);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
   endtask

   task automatic pix_on(input int x, input int y);
      bus.pix_x     = COORD_W'(x);
      bus.pix_y     = COORD_W'(y);
      bus.pix_valid = 1'b1;
   endtask

   function automatic logic [ADDR_W-1:0] addr_of(input int ch);
      return bus.rom_addr[ch*ADDR_W +: ADDR_W];
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      total++; if (bus.visible !== 1'b0) begin bad++; $display("FAIL rst_visible: got %b want 0", bus.visible); end
      total++; if (bus.data !== 8'hE3) begin bad++; $display("FAIL rst_data: got %h want e3", bus.data); end
      total++; if (bus.owner !== 3'd0) begin bad++; $display("FAIL rst_owner: got %0d want 0", bus.owner); end
      total++; if (bus.collision !== 1'b0) begin bad++; $display("FAIL rst_collision: got %b want 0", bus.collision); end
      total++; if (bus.rom_addr !== '0) begin bad++; $display("FAIL rst_rom_addr: got %h want 0", bus.rom_addr); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      set_ch(0, 100, 50, int'(IDLE), 1'b0);
      set_ch(1, 600, 470, int'(IDLE), 1'b0);
      frame_pulse();
      word0 = 8'h1C; word1 = 8'h22;
      pix_on(100, 50);
      @(negedge clk); bus.pix_valid = 1'b0;
      total++; if (addr_of(0) !== 15'd0) begin bad++; $display("FAIL single_addr: got %0d want 0", addr_of(0)); end
      total++; if (bus.rom_sel[3:0] !== 4'd0) begin bad++; $display("FAIL single_sel: got %0d want 0", bus.rom_sel[3:0]); end
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", bus.out_valid); end
      @(negedge clk);
      total++; if (bus.data !== 8'h1C) begin bad++; $display("FAIL single_data: got %h want 1c", bus.data); end
      total++; if (bus.visible !== 1'b1) begin bad++; $display("FAIL single_visible: got %b want 1", bus.visible); end
      total++; if (bus.owner !== 3'd0) begin bad++; $display("FAIL single_owner: got %0d want 0", bus.owner); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
   endtask

   task automatic test_far_edge();
      pix_on(212, 51);
      @(negedge clk); bus.pix_valid = 1'b0;
      total++; if (addr_of(0) !== 15'd225) begin bad++; $display("FAIL edge_addr: got %0d want 225", addr_of(0)); end
      repeat (2) @(negedge clk);
      total++; if (bus.visible !== 1'b1) begin bad++; $display("FAIL edge_in_visible: got %b want 1", bus.visible); end
      pix_on(213, 51);
      @(negedge clk); bus.pix_valid = 1'b0;
      total++; if (addr_of(0) !== 15'd0) begin bad++; $display("FAIL edge_out_addr: got %0d want 0", addr_of(0)); end
      repeat (2) @(negedge clk);
      total++; if (bus.visible !== 1'b0) begin bad++; $display("FAIL edge_out_visible: got %b want 0", bus.visible); end
      total++; if (bus.data !== 8'hE3) begin bad++; $display("FAIL edge_out_data: got %h want e3", bus.data); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL edge_out_valid: got %b want 1", bus.out_valid); end
   endtask

   task automatic test_overlap();
      set_ch(0, 200, 100, int'(IDLE), 1'b0);
      set_ch(1, 200, 100, int'(WALK), 1'b0);
      frame_pulse();
      word0 = 8'h11; word1 = 8'h22;
      pix_on(205, 103);
      @(negedge clk); bus.pix_valid = 1'b0;
      total++; if (addr_of(0) !== 15'd344) begin bad++; $display("FAIL ovl_addr0: got %0d want 344", addr_of(0)); end
      total++; if (addr_of(1) !== 15'd344) begin bad++; $display("FAIL ovl_addr1: got %0d want 344", addr_of(1)); end
      total++; if (bus.rom_sel[7:4] !== 4'd1) begin bad++; $display("FAIL ovl_sel1: got %0d want 1", bus.rom_sel[7:4]); end
      repeat (2) @(negedge clk);
      total++; if (bus.data !== 8'h22) begin bad++; $display("FAIL ovl_data: got %h want 22", bus.data); end
      total++; if (bus.owner !== 3'd1) begin bad++; $display("FAIL ovl_owner: got %0d want 1", bus.owner); end
      total++; if (bus.collision !== 1'b0) begin bad++; $display("FAIL ovl_coll_early: got %b want 0", bus.collision); end
      word1 = 8'hE3;
      pix_on(205, 103);
      @(negedge clk); bus.pix_valid = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.data !== 8'h11) begin bad++; $display("FAIL key_data: got %h want 11", bus.data); end
      total++; if (bus.owner !== 3'd0) begin bad++; $display("FAIL key_owner: got %0d want 0", bus.owner); end
      frame_pulse();
      total++; if (bus.collision !== 1'b1) begin bad++; $display("FAIL coll_set: got %b want 1", bus.collision); end
      pix_on(205, 103);
      @(negedge clk); bus.pix_valid = 1'b0;
      repeat (2) @(negedge clk);
      frame_pulse();
      total++; if (bus.collision !== 1'b0) begin bad++; $display("FAIL coll_clear: got %b want 0", bus.collision); end
   endtask

   task automatic test_mirror();
      logic [ADDR_W-1:0] exp_a, exp_b;
`ifdef SPRITE_MIRROR_EN
      exp_a = 15'd112; exp_b = 15'd337;
`else
      exp_a = 15'd0;   exp_b = 15'd227;
`endif
      set_ch(0, 100, 50, int'(IDLE), 1'b1);
      set_ch(1, 600, 470, int'(IDLE), 1'b0);
      frame_pulse();
      pix_on(100, 50);
      @(negedge clk);
      total++; if (addr_of(0) !== exp_a) begin bad++; $display("FAIL mirror_a: got %0d want %0d", addr_of(0), exp_a); end
      pix_on(101, 52);
      @(negedge clk); bus.pix_valid = 1'b0;
      total++; if (addr_of(0) !== exp_b) begin bad++; $display("FAIL mirror_b: got %0d want %0d", addr_of(0), exp_b); end
      set_ch(0, 100, 50, int'(IDLE), 1'b0);
      frame_pulse();
   endtask

   task automatic test_shadow();
      word0 = 8'h1C; word1 = 8'hE3;
      bus.pos_x[COORD_W-1:0] = 10'd300;
      pix_on(101, 50);
      @(negedge clk); bus.pix_valid = 1'b0;
      total++; if (addr_of(0) !== 15'd1) begin bad++; $display("FAIL shadow_hold_addr: got %0d want 1", addr_of(0)); end
      repeat (2) @(negedge clk);
      total++; if (bus.visible !== 1'b1) begin bad++; $display("FAIL shadow_hold_vis: got %b want 1", bus.visible); end
      bus.frame_start = 1'b1;
      pix_on(301, 50);
      @(negedge clk); bus.pix_valid = 1'b0; bus.frame_start = 1'b0;
      total++; if (addr_of(0) !== 15'd1) begin bad++; $display("FAIL shadow_same_cycle_addr: got %0d want 1", addr_of(0)); end
      repeat (2) @(negedge clk);
      total++; if (bus.visible !== 1'b1) begin bad++; $display("FAIL shadow_same_cycle_vis: got %b want 1", bus.visible); end
      pix_on(101, 50);
      @(negedge clk); bus.pix_valid = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.visible !== 1'b0) begin bad++; $display("FAIL shadow_old_pos_vis: got %b want 0", bus.visible); end
      bus.state[3:0] = 4'd12;
      frame_pulse();
      pix_on(301, 50);
      @(negedge clk); bus.pix_valid = 1'b0;
      total++; if (bus.rom_sel[3:0] !== 4'd12) begin bad++; $display("FAIL badstate_sel: got %0d want 12", bus.rom_sel[3:0]); end
      repeat (2) @(negedge clk);
      total++; if (bus.visible !== 1'b0) begin bad++; $display("FAIL badstate_vis: got %b want 0", bus.visible); end
      total++; if (bus.data !== 8'hE3) begin bad++; $display("FAIL badstate_data: got %h want e3", bus.data); end
   endtask

   task automatic test_reset_mid();
      int lat;
      set_ch(0, 200, 100, int'(IDLE), 1'b0);
      set_ch(1, 200, 100, int'(IDLE), 1'b0);
      frame_pulse();
      word0 = 8'h11; word1 = 8'h22;
      pix_on(205, 103);
      @(negedge clk); bus.pix_valid = 1'b0;
      repeat (2) @(negedge clk);
      frame_pulse();
      total++; if (bus.collision !== 1'b1) begin bad++; $display("FAIL rmid_coll_pre: got %b want 1", bus.collision); end
      pix_on(205, 103);
      @(negedge clk); bus.pix_valid = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.owner !== 3'd1) begin bad++; $display("FAIL rmid_owner_pre: got %0d want 1", bus.owner); end
      rst_n = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %b want 0", bus.out_valid); end
      total++; if (bus.visible !== 1'b0) begin bad++; $display("FAIL rmid_visible: got %b want 0", bus.visible); end
      total++; if (bus.data !== 8'hE3) begin bad++; $display("FAIL rmid_data: got %h want e3", bus.data); end
      total++; if (bus.owner !== 3'd0) begin bad++; $display("FAIL rmid_owner: got %0d want 0", bus.owner); end
      total++; if (bus.collision !== 1'b0) begin bad++; $display("FAIL rmid_collision: got %b want 0", bus.collision); end
      total++; if (bus.rom_addr !== '0) begin bad++; $display("FAIL rmid_rom_addr: got %h want 0", bus.rom_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      frame_pulse();
      total++; if (bus.collision !== 1'b0) begin bad++; $display("FAIL rmid_acc_cleared: got %b want 0", bus.collision); end
      pix_on(205, 103);
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.pix_valid = 1'b0;
         if (bus.out_valid === 1'b1 && lat == 0) lat = k;
      end
      total++; if (lat != 3) begin bad++; $display("FAIL rmid_latency: got %0d want 3", lat); end
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.pix_valid   = 1'b0;
      bus.pix_x       = '0;
      bus.pix_y       = '0;
      bus.pos_x       = '0;
      bus.pos_y       = '0;
      bus.state       = '0;
      bus.facing      = '0;
      test_reset();
      test_single();
      test_far_edge();
      test_overlap();
      test_mirror();
      test_shadow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-channel sprite compositor for the VGA path. It sits between the pixel counter and the colour mux. For each player channel it generates registered sprite-ROM addresses, with optional horizontal mirroring, from positions latched once per frame. It composites the ROM words returned one cycle later with fixed priority and colour-key transparency, and reports the owning channel plus a per-frame sprite-overlap (collision) flag.

## Interface
- NUM_CH, 2, number of sprite channels (1–8)
- SPR_W, 113, sprite width in pixels (ROM row stride)
- SPR_H, 200, sprite height in pixels
- COORD_W, 10, pixel/position coordinate width
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W ≥ SPR_W*SPR_H
- PIX_W, 8, colour word width
- NUM_STATES, 11, valid animation states; state ≥ NUM_STATES renders transparent
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at frame start; latches pos/state/facing
- pix_valid  in  1  current pixel is in the active area
- pix_x, pix_y  in  COORD_W each  current pixel coordinate
- pos_x, pos_y  in  NUM_CH*COORD_W each  channel top-left; channel i occupies slice i
- state  in  NUM_CH*4  animation state per channel
- facing  in  NUM_CH  1 = mirrored (used only with SPRITE_MIRROR_EN)
- rom_addr  out  NUM_CH*ADDR_W  registered address per channel
- rom_sel  out  NUM_CH*4  registered state per channel; selects the ROM bank externally
- rom_data  in  NUM_CH*PIX_W  synchronous-ROM output, valid one cycle after rom_addr
- out_valid  out  1  delayed pix_valid
- visible  out  1  some channel is opaque at this pixel
- data  out  PIX_W  composited colour; TRANSPARENT_COLOR when not visible
- owner  out  3  index of the winning channel; 0 when not visible
- collision  out  1  previous frame had ≥1 pixel where ≥2 channels were opaque

## Operation
- **Shadow registers:** pos/state/facing are captured on frame_start. All rendering uses the shadow copies. A pixel presented in the same cycle as frame_start already uses the new values. Reset value of the shadows is 0.
- **Stage A (edge t+1):** per channel, compute inside = pix_valid ∧ pix_x ≥ pos_x ∧ pix_x < pos_x+SPR_W ∧ same for y.
  - Compare in COORD_W+1 bits so that pos near 2^COORD_W does not wrap.
  - rel_x = pix_x−pos_x, rel_y = pix_y−pos_y.
  - rom_addr = rel_y*SPR_W + rx, where rx = rel_x, or SPR_W−1−rel_x when mirrored.
  - Address 0 is the top-left pixel; there is no offset.
  - When not inside, rom_addr = 0.
  - Register rom_addr, rom_sel, inside_d1 and valid_d1.
- **Stage B (edge t+2):** the ROM returns data; delay inside/valid to _d2.
- **Stage C (edge t+3):**
  - Channel i is opaque iff inside_d2[i] ∧ state_d2[i] < NUM_STATES ∧ rom_data[i] ≠ TRANSPARENT_COLOR.
  - The highest-index opaque channel wins and drives data and owner.
  - visible = OR of opaque.
  - If popcount(opaque) ≥ 2 and valid_d2, set collide_acc.
- **Collision:** on frame_start, collision ← collide_acc and collide_acc ← 0. This happens at the same edge as the shadow latch. A collision sample that lands on that same edge sets the new accumulator.
- **Reset values:** every output 0, except data = TRANSPARENT_COLOR. Shadows, pipeline flags and collide_acc are cleared.

## Timing
- Latency from pix_* to data/visible/owner/out_valid is 3 cycles. Throughput is 1 pixel/cycle with no stalls.
- rom_addr/rom_sel appear 1 cycle after pix_*. The external ROM must have exactly 1 cycle read latency.
- The inside/state flags travel alongside the ROM data, so data and bounds are always aligned. Bounds are never taken combinationally against registered ROM data.
- An asynchronous rst_n assertion mid-frame clears the pipeline immediately. out_valid stays 0 until 3 cycles after the first pix_valid following release.
- frame_start during active video is legal. Pixels already in the pipeline keep the old addresses; new pixels use the new shadows.

## Configuration
- **SPRITE_MIRROR_EN defined:** facing[i]=1 reverses the column index (rx = SPR_W−1−rel_x).
- **SPRITE_MIRROR_EN undefined:** the facing port exists but is ignored, rx = rel_x, and no subtractor is instantiated.

## Structure
- Package sprite_pkg holds:
  - TRANSPARENT_COLOR = 8'hE3
  - the state encoding: IDLE=0, WALK=1, WALKBACK=2, ATK_START=3, ATK_END=4, ATK_PULL=5, DIR_START=6, DIR_END=7, DIR_PULL=8, GOTHIT=9, BLOCK=10
  - typedefs for coordinate and colour words
- Sub-module sprite_channel contains one channel's shadow registers, bounds check, mirror and address generation (stage A). It is instantiated NUM_CH times via generate.
- Priority, collision and output registers live in the top level.

## Test plan
- **Single sprite:** NUM_CH=2, ch0 at (100,50) state 0, ch1 off-screen (600,470), pixel (100,50) → rom_addr[0]=0 at t+1; with ROM word 8'h1C, data=8'h1C, visible=1, owner=0 at t+3.
- **Address and far edge:** pixel (212,51) with ch0 at (100,50) → rom_addr[0]=113+112=225. Pixel (213,51) → inside=0, visible=0, data=8'hE3.
- **Overlap priority:** both channels at (200,100), opaque words 8'h11/8'h22 → data=8'h22, owner=1. Make ch1's word E3 → data=8'h11, owner=0. After the next frame_start, collision=1; after a clean frame, collision=0.
- **Mirror (SPRITE_MIRROR_EN):** facing[0]=1, pixel at rel_x=0,rel_y=0 → rom_addr=112. Without the macro → rom_addr=0.
- **Shadow latch:** change pos_x mid-frame without frame_start → addresses unchanged. Pulse frame_start → the next pixel uses the new pos. An invalid state 12 → channel transparent.
- **Reset mid-frame:** drop rst_n during an overlap pixel → outputs immediately 0, data=8'hE3, collision=0. Release and resume → first out_valid exactly 3 cycles after pix_valid.
